// File: rtl/itof_pipe.sv
// itof_pipe: 3-stage signed int32 -> IEEE-754 single converter with valid/ready handshakes.
// Optional ITOF_INEXACT_FLAG_EN adds out_inexact (guard | sticky), aligned with y.
module itof_pipe #(
    parameter bit ROUND_TIES_AWAY = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y
`ifdef ITOF_INEXACT_FLAG_EN
    ,
    output logic        out_inexact
`endif
);
    logic        v1, s1, v2, s2, z2;
    logic [31:0] mag1, norm2;
    logic [7:0]  e2;
    logic [4:0]  lz;
    logic        adv1, adv2, adv3;
    logic        guard, sticky, rnd;
    logic [24:0] sum;
    logic [31:0] res;

    assign adv3     = !out_valid || out_ready;
    assign adv2     = !v2 || adv3;
    assign adv1     = !v1 || adv2;
    assign in_ready = adv1 && !rst;

    // highest set bit wins, giving the leading-zero count
    always_comb begin
        lz = 5'd0;
        for (int i = 0; i < 32; i++)
            if (mag1[i]) lz = 5'(31 - i);
    end

    assign guard  = norm2[7];
    assign sticky = |norm2[6:0];
    assign rnd    = guard && (sticky || norm2[8] || ROUND_TIES_AWAY);
    assign sum    = {1'b0, norm2[31:8]} + 25'(rnd);
    // a mantissa carry leaves sum[22:0] = 0, so only the exponent needs bumping
    assign res    = z2 ? 32'h0 : {s2, e2 + 8'(sum[24]), sum[22:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            out_valid <= 1'b0;
            y         <= 32'h0;
`ifdef ITOF_INEXACT_FLAG_EN
            out_inexact <= 1'b0;
`endif
        end else begin
            if (adv1) v1 <= in_valid;
            if (adv2) v2 <= v1;
            if (adv3) out_valid <= v2;
            if (adv3 && v2) begin
                y <= res;
`ifdef ITOF_INEXACT_FLAG_EN
                out_inexact <= guard || sticky;
`endif
            end
        end
        if (adv1 && in_valid) begin
            s1   <= x[31];
            mag1 <= x[31] ? -x : x;
        end
        if (adv2 && v1) begin
            s2    <= s1;
            z2    <= mag1 == 32'h0;
            norm2 <= mag1 << lz;
            e2    <= 8'd158 - {3'd0, lz};
        end
    end
endmodule

// File: tb/tb_itof_pipe.sv
// tb_itof_pipe: directed table, random streaming, stall and reset checks against an arithmetic model.
module tb_itof_pipe;
    localparam bit RTA = 1'b0;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [31:0] x = 32'h0, y;
`ifdef ITOF_INEXACT_FLAG_EN
    logic        out_inexact;
`endif
    int          nvec = 0, nerr = 0, cyc = 0;
    logic [32:0] sb[$];
    logic        prev_stall = 1'b0, chk_rst = 1'b0;
    logic [31:0] prev_y = 32'h0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    itof_pipe #(.ROUND_TIES_AWAY(RTA)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .x(x),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y(y)
`ifdef ITOF_INEXACT_FLAG_EN
        ,
        .out_inexact(out_inexact)
`endif
    );

    // value-level rounding: exponent from magnitude, round by remainder vs half-ulp
    function automatic logic [32:0] ref_model(input logic [31:0] v);
        longint m, q, r, half;
        int e;
        m = v[31] ? (64'd1 << 32) - {32'd0, v} : {32'd0, v};
        if (m == 0) return 33'd0;
        e = 0;
        while ((m >> (e + 1)) != 0) e++;
        r = 0;
        half = 0;
        if (e > 23) begin
            q = m >> (e - 23);
            r = m - (q << (e - 23));
            half = 64'd1 << (e - 24);
        end else q = m << (23 - e);
        if (e > 23 && (r > half || (r == half && (q[0] || RTA)))) q++;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e++;
        end
        return {r != 0, v[31], 8'(e + 127), q[22:0]};
    endfunction

    always @(negedge clk) begin
        logic [32:0] e;
        if (chk_rst) begin
            nvec++;
            if (out_valid !== 1'b0 || y !== 32'h0) begin
                nerr++;
                $display("FAIL reset_state: out_valid=%b y=%h, want 0 00000000", out_valid, y);
            end
        end
        if (prev_stall) begin
            nvec++;
            if (out_valid !== 1'b1 || y !== prev_y) begin
                nerr++;
                $display("FAIL stall_hold: out_valid=%b y=%h, want 1 %h", out_valid, y, prev_y);
            end
        end
        nvec++;
        if (in_ready !== (!rst && !(sb.size() == 3 && !out_ready))) begin
            nerr++;
            $display("FAIL in_ready: got %b with %0d in flight, out_ready=%b rst=%b", in_ready, sb.size(), out_ready, rst);
        end
        if (rst) sb.delete();
        else begin
            if (out_valid && out_ready) begin
                nvec++;
                if (sb.size() == 0) begin
                    nerr++;
                    $display("FAIL spurious_output: y=%h with nothing in flight", y);
                end else begin
                    e = sb.pop_front();
`ifdef ITOF_INEXACT_FLAG_EN
                    if (y !== e[31:0] || out_inexact !== e[32]) begin
                        nerr++;
                        $display("FAIL stream_result: y=%h inexact=%b, want %h %b", y, out_inexact, e[31:0], e[32]);
                    end
`else
                    if (y !== e[31:0]) begin
                        nerr++;
                        $display("FAIL stream_result: y=%h, want %h", y, e[31:0]);
                    end
`endif
                end
            end
            if (in_valid && in_ready) sb.push_back(ref_model(x));
        end
        chk_rst = rst;
        prev_stall = !rst && out_valid && !out_ready;
        prev_y = y;
    end

    task automatic send(input logic [31:0] v);
        int t;
        logic ok;
        t = 0;
        in_valid = 1'b1;
        x = v;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 50);
        in_valid = 1'b0;
        if (!ok) begin
            nerr++;
            $display("FAIL send_timeout: x=%h never accepted", v);
        end
    endtask

    task automatic wait_out(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 10);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        nvec++;
        if (sb.size() != 0) begin
            nerr++;
            $display("FAIL drain: %0d results still pending, want 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tv[11];
        int n, c0, refused;
        logic acc;
        tv[0]  = '{32'd1,        32'h3F800000};
        tv[1]  = '{32'hFFFFFFFF, 32'hBF800000};
        tv[2]  = '{32'd0,        32'h00000000};
        tv[3]  = '{32'h80000000, 32'hCF000000};
        tv[4]  = '{32'h7FFFFFFF, 32'h4F000000};
        tv[5]  = '{32'd16777217, RTA ? 32'h4B800001 : 32'h4B800000};
        tv[6]  = '{32'd16777219, 32'h4B800002};
        tv[7]  = '{32'd1024,     32'h44800000};
        tv[8]  = '{32'hFFFFFFFB, 32'hC0A00000};
        tv[9]  = '{32'h00FFFFFF, 32'h4B7FFFFF};
        tv[10] = '{32'h01000000, 32'h4B800000};
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            send(tv[i].x);
            wait_out(n);
            nvec++;
            if (n != 3 || y !== tv[i].y) begin
                nerr++;
                $display("FAIL vec%0d x=%h: y=%h latency=%0d, want %h latency=3", i, tv[i].x, y, n, tv[i].y);
            end
            @(posedge clk);
            #1;
        end

        c0 = cyc;
        for (int i = 0; i < 100; i++) send($urandom);
        nvec++;
        if (cyc - c0 != 100) begin
            nerr++;
            $display("FAIL throughput: 100 accepts took %0d cycles, want 100", cyc - c0);
        end
        drain();

        refused = 0;
        x = $urandom;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 8 && c < 14);
            in_valid = 1'b1;
            @(negedge clk);
            acc = in_ready;
            if (!acc) refused++;
            @(posedge clk);
            #1;
            if (acc) x = $urandom;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        nvec++;
        if (refused == 0) begin
            nerr++;
            $display("FAIL stall_backpressure: in_ready never dropped, refused=%0d", refused);
        end
        drain();

        send(32'd5);
        send(32'hFFFFFF00);
        send(32'd123456789);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        send(32'd1);
        wait_out(n);
        nvec++;
        if (n != 3 || y !== 32'h3F800000) begin
            nerr++;
            $display("FAIL post_reset_first: y=%h latency=%0d, want 3F800000 latency=3", y, n);
        end
        @(posedge clk);
        #1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
